// File: rtl/mod_sin_adder_pkg.sv
// Shared constants for the single-add responder: FSM state encoding, default widths
// and the accumulator saturation bounds.
package mod_sin_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_ACC  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_WEIGHT_W = 8;
  localparam int DEF_ACC_W    = 20;

  // Bounds are returned in 64 bits; callers keep the low accW bits.
  function automatic logic [63:0] satMax(input int accW);
    return (64'd1 << (accW - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] satMin(input int accW);
    return ~satMax(accW);
  endfunction

endpackage

// File: rtl/mod_sin_adder_shift_mul.sv
// Serial unsigned shift-add multiplier: one multiplier bit per cycle, LSB first.
// lastStep flags the cycle whose edge completes the product.
module mod_shift_mul #(
  parameter int A_W = 8,
  parameter int B_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [A_W-1:0]     aMag,
  input  logic [B_W-1:0]     bMag,
  output logic [A_W+B_W-1:0] product,
  output logic               lastStep
);

  localparam int P_W = A_W + B_W;
  localparam int CNT_W = (B_W > 1) ? $clog2(B_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(B_W - 1);

  logic [A_W-1:0]   aMag_r;
  logic [B_W-1:0]   bMag_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic [P_W-1:0]   addend_s;

  assign lastStep = busy_r && (cnt_r == LAST_CNT);
  assign addend_s = P_W'(aMag_r) << cnt_r;

  // Operand latch, bit counter and partial-product accumulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aMag_r  <= {A_W{1'b0}};
      bMag_r  <= {B_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
      product <= {P_W{1'b0}};
    end else if (start) begin
      aMag_r  <= aMag;
      bMag_r  <= bMag;
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b1;
      product <= {P_W{1'b0}};
    end else if (busy_r) begin
      if (bMag_r[cnt_r]) begin
        product <= product + addend_s;
      end else begin
        product <= product;
      end
      cnt_r  <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      busy_r <= !lastStep;
    end else begin
      product <= product;
    end
  end

endmodule

// File: rtl/mod_sin_adder.sv
// Single-add responder: signed multiply via mod_shift_mul, accumulate, four-phase done.
// Define SIN_ADDER_SAT_EN for saturating accumulation with a sticky satFlag.
module mod_sin_adder
  import mod_sin_adder_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int ACC_W    = DEF_ACC_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       startAdd,
  input  logic signed [DATA_W-1:0]   inVal,
  input  logic signed [WEIGHT_W-1:0] weight,
  input  logic                       clrAcc,
  output logic                       sinAddFin,
  output logic signed [ACC_W-1:0]    accOut,
  output logic                       satFlag
);

  localparam int PROD_W = DATA_W + WEIGHT_W;
`ifdef SIN_ADDER_SAT_EN
  localparam int EXT_W = ACC_W + 1;
  localparam logic [63:0] SAT_MAX_64 = satMax(ACC_W);
  localparam logic [63:0] SAT_MIN_64 = satMin(ACC_W);
  localparam logic [ACC_W-1:0] SAT_MAX = SAT_MAX_64[ACC_W-1:0];
  localparam logic [ACC_W-1:0] SAT_MIN = SAT_MIN_64[ACC_W-1:0];
  logic [EXT_W-1:0] sumExt_s;
  logic             satHit_s;
`else
  localparam int EXT_W = ACC_W;
`endif

  logic [1:0]          state_r;
  logic                neg_r;
  logic                accept_s;
  logic                mulLast_s;
  logic [DATA_W-1:0]   inMag_s;
  logic [WEIGHT_W-1:0] wMag_s;
  logic [PROD_W-1:0]   product_s;
  logic [EXT_W-1:0]    prodExt_s;
  logic [EXT_W-1:0]    signedProd_s;
  logic [ACC_W-1:0]    accNext_s;

  assign accept_s = (state_r == ST_IDLE) && startAdd;

  // Operand magnitudes; the most negative value maps to its unsigned magnitude.
  always_comb begin
    if (inVal[DATA_W-1]) begin
      inMag_s = -inVal;
    end else begin
      inMag_s = inVal;
    end
    if (weight[WEIGHT_W-1]) begin
      wMag_s = -weight;
    end else begin
      wMag_s = weight;
    end
  end

  mod_shift_mul #(
    .A_W(DATA_W),
    .B_W(WEIGHT_W)
  ) uMul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept_s),
    .aMag    (inMag_s),
    .bMag    (wMag_s),
    .product (product_s),
    .lastStep(mulLast_s)
  );

  // Signed product and next accumulator value (wrapped or clamped).
  always_comb begin
    prodExt_s = EXT_W'(product_s);
    if (neg_r) begin
      signedProd_s = -prodExt_s;
    end else begin
      signedProd_s = prodExt_s;
    end
`ifdef SIN_ADDER_SAT_EN
    sumExt_s = {accOut[ACC_W-1], accOut} + signedProd_s;
    if (sumExt_s[ACC_W] != sumExt_s[ACC_W-1]) begin
      satHit_s = 1'b1;
      if (sumExt_s[ACC_W]) begin
        accNext_s = SAT_MIN;
      end else begin
        accNext_s = SAT_MAX;
      end
    end else begin
      satHit_s  = 1'b0;
      accNext_s = sumExt_s[ACC_W-1:0];
    end
`else
    accNext_s = accOut + signedProd_s;
`endif
  end

  // Handshake FSM, sign latch and accumulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      neg_r     <= 1'b0;
      sinAddFin <= 1'b0;
      accOut    <= {ACC_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (clrAcc) begin
            accOut <= {ACC_W{1'b0}};
          end
          if (startAdd) begin
            neg_r   <= inVal[DATA_W-1] ^ weight[WEIGHT_W-1];
            state_r <= ST_MUL;
          end
        end
        ST_MUL: begin
          if (mulLast_s) begin
            state_r <= ST_ACC;
          end
        end
        ST_ACC: begin
          accOut    <= accNext_s;
          sinAddFin <= 1'b1;
          state_r   <= ST_DONE;
        end
        ST_DONE: begin
          if (!startAdd) begin
            sinAddFin <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          sinAddFin <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SIN_ADDER_SAT_EN
  // Sticky saturation indicator, cleared together with the accumulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      satFlag <= 1'b0;
    end else if ((state_r == ST_IDLE) && clrAcc) begin
      satFlag <= 1'b0;
    end else if ((state_r == ST_ACC) && satHit_s) begin
      satFlag <= 1'b1;
    end else begin
      satFlag <= satFlag;
    end
  end
`else
  assign satFlag = 1'b0;
`endif

endmodule

// File: tb/tb_mod_sin_adder.sv
// Bench for mod_sin_adder: a default instance and an ACC_W=16 instance share stimulus
// and are checked against integer-arithmetic reference accumulators.
module tb_mod_sin_adder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic startAdd = 1'b0;
  logic clrAcc = 1'b0;
  logic signed [7:0] inVal = 8'sd0;
  logic signed [7:0] weight = 8'sd0;
  logic fin20, fin16, sat20, sat16;
  logic signed [19:0] acc20;
  logic signed [15:0] acc16;

  int nChecks = 0;
  int nErrors = 0;
  longint mAcc20 = 0;
  longint mAcc16 = 0;
  bit mSat20 = 1'b0;
  bit mSat16 = 1'b0;

  always #5 clk = ~clk;

  mod_sin_adder dut (
    .clk(clk), .rst(rst), .startAdd(startAdd), .inVal(inVal), .weight(weight),
    .clrAcc(clrAcc), .sinAddFin(fin20), .accOut(acc20), .satFlag(sat20)
  );

  mod_sin_adder #(.ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .startAdd(startAdd), .inVal(inVal), .weight(weight),
    .clrAcc(clrAcc), .sinAddFin(fin16), .accOut(acc16), .satFlag(sat16)
  );

  task automatic checkVal(input string tag, input longint got, input longint exp);
    nChecks++;
    if (got != exp) begin
      nErrors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: exact integer sum, then clamp or wrap into accW bits.
  function automatic longint accModel(input longint acc, input longint p, input int accW,
                                      inout bit sat);
    longint full;
    longint lim;
    full = acc + p;
    lim = longint'(1) <<< (accW - 1);
`ifdef SIN_ADDER_SAT_EN
    if (full > lim - 1) begin
      sat = 1'b1;
      return lim - 1;
    end
    if (full < -lim) begin
      sat = 1'b1;
      return -lim;
    end
    return full;
`else
    full = full % (2 * lim);
    if (full >= lim) full -= 2 * lim;
    else if (full < -lim) full += 2 * lim;
    return full;
`endif
  endfunction

  task automatic checkOutputs(input string tag);
    checkVal({tag, "_acc20"}, longint'(acc20), mAcc20);
    checkVal({tag, "_acc16"}, longint'(acc16), mAcc16);
    checkVal({tag, "_sat20"}, longint'(sat20), longint'(mSat20));
    checkVal({tag, "_sat16"}, longint'(sat16), longint'(mSat16));
  endtask

  // One add: dropK>0 drops startAdd after edge E<dropK>, midClr pulses clrAcc during MUL.
  task automatic doAdd(input int a, input int w, input bit clr, input bit midClr,
                       input int dropK, input int holdExtra);
    int k;
    int junk;
    longint prod;
    prod = longint'(a) * longint'(w);
    @(negedge clk);
    inVal = a[7:0];
    weight = w[7:0];
    startAdd = 1'b1;
    clrAcc = clr;
    @(posedge clk);
    if (clr) begin
      mAcc20 = 0; mAcc16 = 0; mSat20 = 1'b0; mSat16 = 1'b0;
    end
    #1;
    clrAcc = 1'b0;
    k = 0;
    while (k < 20 && !fin20) begin
      @(posedge clk);
      #1;
      k++;
      if (k == 1) begin
        junk = $urandom;
        inVal = junk[7:0];
        weight = junk[15:8];
      end
      if (k == dropK) startAdd = 1'b0;
      if (midClr && k == 3) clrAcc = 1'b1;
      if (k == 4) begin
        clrAcc = 1'b0;
        checkOutputs("midMul");
      end
    end
    checkVal("finLatency", longint'(k), 64'sd9);
    checkVal("fin16Rise", longint'(fin16), 64'sd1);
    mAcc20 = accModel(mAcc20, prod, 20, mSat20);
    mAcc16 = accModel(mAcc16, prod, 16, mSat16);
    checkOutputs("result");
    for (int h = 0; h < holdExtra && startAdd; h++) begin
      @(posedge clk);
      #1;
      checkVal("finHold", longint'(fin20), 64'sd1);
    end
    startAdd = 1'b0;
    @(posedge clk);
    #1;
    checkVal("finFall", longint'(fin20), 64'sd0);
    checkVal("fin16Fall", longint'(fin16), 64'sd0);
  endtask

  task automatic doResetMid(input int a, input int w);
    @(negedge clk);
    inVal = a[7:0];
    weight = w[7:0];
    startAdd = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 4; k++) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    mAcc20 = 0; mAcc16 = 0; mSat20 = 1'b0; mSat16 = 1'b0;
    checkOutputs("midReset");
    checkVal("midResetFin", longint'(fin20), 64'sd0);
    @(negedge clk);
    startAdd = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    int a;
    int w;
    int r;
    repeat (3) @(posedge clk);
    #1;
    checkOutputs("reset");
    checkVal("resetFin", longint'(fin20), 64'sd0);
    @(negedge clk);
    rst = 1'b1;

    doAdd(3, 5, 1'b0, 1'b0, 0, 2);
    doAdd(-4, 7, 1'b0, 1'b0, 0, 0);
    doAdd(-128, -128, 1'b0, 1'b0, 0, 1);
    doAdd(3, 5, 1'b1, 1'b0, 0, 0);
    doAdd(2, 2, 1'b1, 1'b1, 0, 0);
    doAdd(-7, 9, 1'b0, 1'b0, 3, 0);
    doAdd(127, 127, 1'b1, 1'b0, 0, 0);
    doAdd(127, 127, 1'b0, 1'b1, 0, 0);
    doAdd(127, 127, 1'b0, 1'b0, 0, 0);
    doResetMid(100, 100);
    doAdd(-50, 3, 1'b0, 1'b0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      a = $urandom_range(0, 255);
      w = $urandom_range(0, 255);
      doAdd(a - 128, w - 128, (r[3:0] == 4'd0), r[4], r[5] ? 3 : 0, r[7:6]);
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/mod_sin_adder.md
# mod_sin_adder

Single-add responder for the neuron adder controller. It takes one `startAdd` request, multiplies the presented input value by its synapse weight with a serial shift-add multiplier, and accumulates the product into the neuron accumulator. It then raises `sinAddFin` under a four-phase handshake. It sits beside the adder FSM, which issues `startAdd` and waits for `sinAddFin`, and holds the running neuron sum read by the downstream activation logic.

## Interface
Parameters:
- `DATA_W`, 8 — signed input value width
- `WEIGHT_W`, 8 — signed weight width; also the multiply cycle count
- `ACC_W`, 20 — signed accumulator width; must be ≥ `DATA_W+WEIGHT_W`

Ports:
- `clk` in 1 — single clock; all state changes on the rising edge
- `rst` in 1 — asynchronous, active-low reset
- `startAdd` in 1 — request level from the adder FSM
- `inVal` in `DATA_W` — signed input; sampled at accept
- `weight` in `WEIGHT_W` — signed weight; sampled at accept
- `clrAcc` in 1 — synchronous accumulator clear; honoured only in IDLE
- `sinAddFin` out 1 — add-complete level (registered)
- `accOut` out `ACC_W` — signed accumulator value (registered)
- `satFlag` out 1 — sticky saturation indicator

## Operation
- Reset values: state IDLE; `sinAddFin`=0; `accOut`=0; `satFlag`=0; multiplier registers=0.
- States: IDLE, MUL, ACC, DONE.
- IDLE:
  - If `clrAcc`=1, zero `accOut` and `satFlag`.
  - If `startAdd`=1, latch `|inVal|`, `|weight|` and product sign (XOR of sign bits), clear the partial product and bit counter, then go to MUL.
  - If both are high, the clear and the accept both occur.
- MUL: one weight bit per cycle, LSB first. If the bit is set, add the magnitude of `inVal`, shifted by the count, to the partial product. After `WEIGHT_W` cycles, go to ACC.
- Magnitudes are `DATA_W` and `WEIGHT_W` bits unsigned, so -128 gives 128. The product is `DATA_W+WEIGHT_W` bits unsigned.
- ACC:
  - Apply the sign and sign-extend to `ACC_W+1`.
  - Add to `accOut` (see Configuration).
  - Set `sinAddFin`=1 and go to DONE.
- DONE: hold `sinAddFin`=1 while `startAdd`=1. When `startAdd`=0 is sampled, clear `sinAddFin` and return to IDLE.
- `clrAcc` is ignored in MUL, ACC and DONE.
- `startAdd` dropping early (protocol violation): the operation still completes. DONE then sees `startAdd`=0, so `sinAddFin` is a one-cycle pulse.
- `inVal` and `weight` changing after accept have no effect.
- Reset mid-operation: immediate return to reset values. The partial result is lost.

## Timing
- Accept edge = E0, the IDLE edge that samples `startAdd`=1.
- Edges E1..E`WEIGHT_W` perform the multiply.
- Edge E`WEIGHT_W+1` updates `accOut` and raises `sinAddFin`. With defaults, `sinAddFin` is visible 9 cycles after E0.
- `sinAddFin` falls on the first edge that samples `startAdd`=0 in DONE. The earliest next accept is the following edge.
- Throughput: one add per `WEIGHT_W+3` cycles minimum.
- `accOut` changes only at the ACC edge, on an IDLE clear, or on reset.

## Configuration
- `SIN_ADDER_SAT_EN` defined:
  - ACC saturates to +2^(`ACC_W`-1)-1 or -2^(`ACC_W`-1) on overflow.
  - `satFlag` is set on any saturation and stays set until `clrAcc` or reset.
- `SIN_ADDER_SAT_EN` undefined:
  - Two's-complement wrap-around in `ACC_W` bits.
  - `satFlag` is tied 0.

## Structure
- Package `mod_sin_adder_pkg` holds:
  - the state encoding constants (IDLE=0, MUL=1, ACC=2, DONE=3)
  - default width constants
  - the saturation min/max function of `ACC_W`
- Sub-module `mod_shift_mul` contains the serial unsigned shift-add multiplier with start/count/done. The top level owns the sign handling, accumulation and handshake FSM.

## Test plan
All cases use default parameters unless stated.
- Reset, then `inVal`=3, `weight`=5, hold `startAdd`=1 → `sinAddFin` rises 9 cycles after accept, `accOut`=15; drop `startAdd` → `sinAddFin`=0 next edge, IDLE.
- Following that, `inVal`=-4, `weight`=7 → `accOut`=-13; then `inVal`=-128, `weight`=-128 → `accOut`=16371.
- `clrAcc` and `startAdd` together in IDLE with `accOut`=15 and `inVal`=2, `weight`=2 → `accOut`=4. `clrAcc` pulsed during MUL is ignored.
- `ACC_W`=16 override, three adds of 127×127 → with `SIN_ADDER_SAT_EN`, `accOut`=32767 and `satFlag`=1; without it, `accOut`=-17149 and `satFlag`=0.
- `startAdd` dropped at E3 → add completes, `sinAddFin` is a single-cycle pulse, `accOut` is correct.
- `rst` asserted at E4 of an add → all outputs 0 immediately; the next request proceeds normally from `accOut`=0.
